// File: rtl/csi_pkg.sv
// Shared constants and beat payload for the CSI stereo line arbiter.
package csi_pkg;

  localparam int unsigned AXIS_DW = 32;
  localparam int unsigned ST_W    = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_GNT0 = 2'd1;
  localparam logic [ST_W-1:0] ST_GNT1 = 2'd2;

  localparam logic SRC_LEFT  = 1'b0;
  localparam logic SRC_RIGHT = 1'b1;

  typedef struct packed {
    logic [AXIS_DW-1:0] tdata;
    logic               tuser;
    logic               tlast;
  } axis_beat_t;

endpackage

// File: rtl/csi_axis_mux2.sv
// Grant-indexed 2:1 AXI4-Stream mux with tready steering; idle when no grant.
module csi_axis_mux2
  import csi_pkg::*;
(
  input  logic       gnt_vld,
  input  logic       gnt_sel,
  input  logic       s0_tvalid,
  input  axis_beat_t s0_beat,
  input  logic       s1_tvalid,
  input  axis_beat_t s1_beat,
  input  logic       m_tready,
  output logic       s0_tready,
  output logic       s1_tready,
  output logic       m_tvalid,
  output axis_beat_t m_beat,
  output logic [3:0] m_tdest
);

  always_comb begin
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    m_tvalid  = 1'b0;
    m_beat    = '0;
    m_tdest   = 4'h0;
    if (gnt_vld) begin
      if (gnt_sel == SRC_RIGHT) begin
        s1_tready = m_tready;
        m_tvalid  = s1_tvalid;
        m_beat    = s1_beat;
        m_tdest   = 4'h1;
      end else begin
        s0_tready = m_tready;
        m_tvalid  = s0_tvalid;
        m_beat    = s0_beat;
      end
    end
  end

endmodule

// File: rtl/csi_stereo_arb.sv
// Round-robin whole-line arbiter of two CSI streams onto one AXI4-Stream path,
// with per-source SOF counters and an over-length line watchdog.
module csi_stereo_arb
  import csi_pkg::*;
#(
  parameter int unsigned MAX_LINE = 4096,
  parameter int unsigned FCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enb,
  input  logic                err_clr,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic                s0_tuser,
  input  logic                s0_tlast,
  input  logic [AXIS_DW-1:0]  s0_tdata,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  input  logic                s1_tuser,
  input  logic                s1_tlast,
  input  logic [AXIS_DW-1:0]  s1_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tuser,
  output logic                m_tlast,
  output logic [AXIS_DW-1:0]  m_tdata,
  output logic [3:0]          m_tdest,
  output logic [3:0]          m_tkeep,
  output logic [FCNT_W-1:0]   frm_cnt0,
  output logic [FCNT_W-1:0]   frm_cnt1,
  output logic                err_long,
  output logic                busy
);

  localparam int unsigned BEAT_W = 16;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_LINE - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic              last_src_q, last_src_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [FCNT_W-1:0] frm_cnt0_q, frm_cnt0_d;
  logic [FCNT_W-1:0] frm_cnt1_q, frm_cnt1_d;
  logic              err_long_q, err_long_d;

  logic       gnt_vld;
  logic       gnt_sel;
  logic       force_last;
  logic       xfer;
  axis_beat_t s0_beat;
  axis_beat_t s1_beat;
  axis_beat_t mux_beat;

  assign gnt_vld    = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign gnt_sel    = (state_q == ST_GNT1);
  assign force_last = gnt_vld && (beat_cnt_q == BEAT_LAST);
  assign s0_beat    = '{tdata: s0_tdata, tuser: s0_tuser, tlast: s0_tlast};
  assign s1_beat    = '{tdata: s1_tdata, tuser: s1_tuser, tlast: s1_tlast};

  csi_axis_mux2 u_mux (
    .gnt_vld   (gnt_vld),
    .gnt_sel   (gnt_sel),
    .s0_tvalid (s0_tvalid),
    .s0_beat   (s0_beat),
    .s1_tvalid (s1_tvalid),
    .s1_beat   (s1_beat),
    .m_tready  (m_tready),
    .s0_tready (s0_tready),
    .s1_tready (s1_tready),
    .m_tvalid  (m_tvalid),
    .m_beat    (mux_beat),
    .m_tdest   (m_tdest)
  );

  assign xfer = m_tvalid && m_tready;

  // Next-state: grant in IDLE, count beats and close lines while granted.
  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    beat_cnt_d = beat_cnt_q;
    frm_cnt0_d = frm_cnt0_q;
    frm_cnt1_d = frm_cnt1_q;
    err_long_d = err_long_q;

    if (err_clr) err_long_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enb) begin
          if (s0_tvalid && s1_tvalid)
            state_d = (last_src_q == SRC_RIGHT) ? ST_GNT0 : ST_GNT1;
          else if (s0_tvalid)
            state_d = ST_GNT0;
          else if (s1_tvalid)
            state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (xfer) begin
          if (mux_beat.tlast || force_last) begin
            state_d    = ST_IDLE;
            last_src_d = gnt_sel;
            beat_cnt_d = '0;
            if (!mux_beat.tlast) err_long_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
          if (mux_beat.tuser && (gnt_sel == SRC_LEFT))  frm_cnt0_d = frm_cnt0_q + FCNT_W'(1);
          if (mux_beat.tuser && (gnt_sel == SRC_RIGHT)) frm_cnt1_d = frm_cnt1_q + FCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_src_q <= SRC_RIGHT;
      beat_cnt_q <= '0;
      frm_cnt0_q <= '0;
      frm_cnt1_q <= '0;
      err_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      beat_cnt_q <= beat_cnt_d;
      frm_cnt0_q <= frm_cnt0_d;
      frm_cnt1_q <= frm_cnt1_d;
      err_long_q <= err_long_d;
    end
  end

  assign m_tdata  = mux_beat.tdata;
  assign m_tuser  = mux_beat.tuser;
  assign m_tlast  = mux_beat.tlast || force_last;
  assign m_tkeep  = 4'hF;
  assign frm_cnt0 = frm_cnt0_q;
  assign frm_cnt1 = frm_cnt1_q;
  assign err_long = err_long_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csi_stereo_arb.sv
// Self-checking bench for csi_stereo_arb: per-cycle comparison against a
// line-level reference model driven by queued source lines.
module tb_csi_stereo_arb;

  localparam int unsigned MAX_LINE = 16;
  localparam int unsigned FCNT_W   = 3;
  localparam int          FMOD     = 1 << FCNT_W;

  logic              clk, rst_n, enb, err_clr;
  logic              s0_tvalid, s0_tready, s0_tuser, s0_tlast;
  logic [31:0]       s0_tdata;
  logic              s1_tvalid, s1_tready, s1_tuser, s1_tlast;
  logic [31:0]       s1_tdata;
  logic              m_tvalid, m_tready, m_tuser, m_tlast;
  logic [31:0]       m_tdata;
  logic [3:0]        m_tdest, m_tkeep;
  logic [FCNT_W-1:0] frm_cnt0, frm_cnt1;
  logic              err_long, busy;

  csi_stereo_arb #(.MAX_LINE(MAX_LINE), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enb(enb), .err_clr(err_clr),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tuser(s0_tuser),
    .s0_tlast(s0_tlast), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tuser(s1_tuser),
    .s1_tlast(s1_tlast), .s1_tdata(s1_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tkeep(m_tkeep),
    .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .err_long(err_long), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          u;
    bit          l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  bit    sv[2];
  int    line_src[$];

  // Reference model: who owns the path, beats taken, last winner, counters.
  int owner, cnt, last_w;
  int frm[2];
  bit err;

  int p_vld, p_rdy;
  bit enb_k, clr_k, rnd_ctl;
  int n_cmp, n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int s, input int len, input bit sof);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = $urandom;
      b.u = sof && (i == 0);
      b.l = (i == len - 1);
      if (s == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic model_reset();
    owner = -1; cnt = 0; last_w = 1; err = 1'b0;
    frm[0] = 0; frm[1] = 0;
  endtask

  task automatic step();
    beat_t hb;
    bit    exp_v, rdy, set_err;
    @(negedge clk);
    if (q0.size() == 0) sv[0] = 1'b0;
    else if (!sv[0] && $urandom_range(99) < p_vld) sv[0] = 1'b1;
    if (q1.size() == 0) sv[1] = 1'b0;
    else if (!sv[1] && $urandom_range(99) < p_vld) sv[1] = 1'b1;
    if (rnd_ctl) begin
      enb_k = ($urandom_range(9) != 0);
      clr_k = ($urandom_range(19) == 0);
    end
    rdy = ($urandom_range(99) < p_rdy);
    s0_tvalid = sv[0];
    s1_tvalid = sv[1];
    if (q0.size() > 0) begin
      s0_tdata = q0[0].d; s0_tuser = q0[0].u; s0_tlast = q0[0].l;
    end else begin
      s0_tdata = '0; s0_tuser = 1'b0; s0_tlast = 1'b0;
    end
    if (q1.size() > 0) begin
      s1_tdata = q1[0].d; s1_tuser = q1[0].u; s1_tlast = q1[0].l;
    end else begin
      s1_tdata = '0; s1_tuser = 1'b0; s1_tlast = 1'b0;
    end
    m_tready = rdy;
    enb      = enb_k;
    err_clr  = clr_k;
    #1;
    exp_v = (owner >= 0) && sv[owner];
    chk("m_tvalid",  32'(m_tvalid),  32'(exp_v));
    chk("s0_tready", 32'(s0_tready), 32'((owner == 0) && rdy));
    chk("s1_tready", 32'(s1_tready), 32'((owner == 1) && rdy));
    chk("busy",      32'(busy),      32'(owner >= 0));
    chk("err_long",  32'(err_long),  32'(err));
    chk("frm_cnt0",  32'(frm_cnt0),  32'(frm[0]));
    chk("frm_cnt1",  32'(frm_cnt1),  32'(frm[1]));
    chk("m_tkeep",   32'(m_tkeep),   32'hF);
    if (exp_v) begin
      hb = (owner == 0) ? q0[0] : q1[0];
      chk("m_tdata", m_tdata,         hb.d);
      chk("m_tuser", 32'(m_tuser),    32'(hb.u));
      chk("m_tlast", 32'(m_tlast),    32'(hb.l || (cnt == MAX_LINE - 1)));
      chk("m_tdest", 32'(m_tdest),    owner);
    end
    if (m_tvalid && m_tready && m_tlast) line_src.push_back(int'(m_tdest));

    set_err = 1'b0;
    if (owner >= 0) begin
      if (exp_v && rdy) begin
        if (owner == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        sv[owner] = 1'b0;
        if (hb.u) frm[owner] = (frm[owner] + 1) % FMOD;
        if (hb.l || cnt == MAX_LINE - 1) begin
          set_err = !hb.l;
          last_w  = owner;
          owner   = -1;
          cnt     = 0;
        end else begin
          cnt++;
        end
      end
    end else if (enb_k) begin
      if (sv[0] && sv[1]) owner = (last_w == 1) ? 0 : 1;
      else if (sv[0])     owner = 0;
      else if (sv[1])     owner = 1;
    end
    if (set_err) err = 1'b1;
    else if (clr_k) err = 1'b0;
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  int n;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; enb = 1'b0; err_clr = 1'b0; m_tready = 1'b0;
    s0_tvalid = 1'b0; s0_tuser = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    s1_tvalid = 1'b0; s1_tuser = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    sv[0] = 1'b0; sv[1] = 1'b0;
    enb_k = 1'b1; clr_k = 1'b0; rnd_ctl = 1'b0; p_vld = 100; p_rdy = 100;
    model_reset();

    #12;
    chk("rst_m_tvalid",  32'(m_tvalid),  32'd0);
    chk("rst_s0_tready", 32'(s0_tready), 32'd0);
    chk("rst_s1_tready", 32'(s1_tready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_err_long",  32'(err_long),  32'd0);
    chk("rst_frm_cnt0",  32'(frm_cnt0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source line within the length limit.
    load(0, 12, 1'b1);
    drain(100, n);
    chk("single_line_cycles", n, 13);

    // Both sources continuously valid: alternation with one bubble per line.
    line_src.delete();
    for (int i = 0; i < 4; i++) begin
      load(0, 8, 1'b1);
      load(1, 8, 1'b1);
    end
    drain(200, n);
    chk("alt_cycles", n, 72);
    chk("alt_lines", line_src.size(), 8);
    for (int i = 0; i < 8 && i < line_src.size(); i++)
      chk("alt_order", line_src[i], (i % 2 == 0) ? 1 : 0);

    // Backpressure on an s1 line.
    p_rdy = 50;
    load(1, 8, 1'b1);
    drain(300, n);
    p_rdy = 100;

    // Over-length s0 line: forced end at beat 16, remainder as its own line.
    line_src.delete();
    load(0, 20, 1'b1);
    drain(200, n);
    chk("long_err_set", 32'(err_long), 32'd1);
    chk("long_lines", line_src.size(), 2);
    clr_k = 1'b1;
    step();
    clr_k = 1'b0;
    step();
    chk("long_err_clr", 32'(err_long), 32'd0);

    // enb dropped mid-line: line completes, then no new grants.
    load(0, 8, 1'b1);
    load(1, 8, 1'b1);
    n = 0;
    while (!(owner >= 0 && cnt == 3) && n < 50) begin
      step();
      n++;
    end
    chk("enb_reach_beat3", 32'(n < 50), 32'd1);
    enb_k = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("enb_hold_idle", 32'(busy), 32'd0);
    chk("enb_line_left", q0.size() + q1.size(), 8);
    enb_k = 1'b1;
    drain(100, n);

    // Randomized traffic, lengths around the watchdog limit, random enb/clear.
    p_vld = 70; p_rdy = 70; rnd_ctl = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        load(0, 1 + $urandom_range(19), $urandom_range(1) == 1);
        load(1, 1 + $urandom_range(19), $urandom_range(1) == 1);
      end
      drain(3000, n);
    end
    rnd_ctl = 1'b0; enb_k = 1'b1; clr_k = 1'b0; p_vld = 100; p_rdy = 100;

    // Asynchronous reset in the middle of a line.
    load(0, 10, 1'b1);
    load(1, 10, 1'b1);
    n = 0;
    while (!(owner >= 0 && cnt >= 3) && n < 50) begin
      step();
      n++;
    end
    chk("rst_reach_mid", 32'(n < 50), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid",  32'(m_tvalid),  32'd0);
    chk("arst_s0_tready", 32'(s0_tready), 32'd0);
    chk("arst_s1_tready", 32'(s1_tready), 32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_err",       32'(err_long),  32'd0);
    chk("arst_frm0",      32'(frm_cnt0),  32'd0);
    chk("arst_frm1",      32'(frm_cnt1),  32'd0);
    q0.delete(); q1.delete();
    sv[0] = 1'b0; sv[1] = 1'b0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    line_src.delete();
    for (int i = 0; i < 2; i++) begin
      load(0, 5, 1'b1);
      load(1, 5, 1'b1);
    end
    drain(200, n);
    chk("post_rst_lines", line_src.size(), 4);
    if (line_src.size() > 0) chk("post_rst_first_src", line_src[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
